// File: rtl/serv_dbus_pkg.sv
// -----------------------------------------------------------------------------
// serv_dbus_pkg
// Shared definitions for the SERV data-bus responder:
//   state_t   - responder FSM encoding (IDLE / WAIT / ACK)
//   CNT_W     - width of the wait-state counter (WAIT parameter range 0..15)
//   NUM_LANES - number of byte lanes in a 32-bit bus word
// -----------------------------------------------------------------------------
package serv_dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int CNT_W     = 4;
  localparam int NUM_LANES = 4;

endpackage

// File: rtl/serv_dbus_ram.sv
// -----------------------------------------------------------------------------
// serv_dbus_ram
// DEPTH x 32 word memory with per-byte write enables and a registered read
// port. The array itself is never reset; only the read-data register is.
//
// Ports:
//   clk_i    clock
//   rst_i    async active-high reset (read register only)
//   we_i     write strobe; lanes with sel_i[n]=1 take dat_i[8n+7:8n]
//   sel_i    byte lane enables
//   adr_i    word index
//   dat_i    write data
//   re_i     load strobe; rdt_o takes the addressed word at the edge
//   clr_i    zero rdt_o at the edge (out-of-range load)
//   rdt_o    registered read data, holds between loads
// -----------------------------------------------------------------------------
module serv_dbus_ram
  import serv_dbus_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [NUM_LANES-1:0] sel_i,
  input  logic [AW-1:0]        adr_i,
  input  logic [31:0]          dat_i,
  input  logic                 re_i,
  input  logic                 clr_i,
  output logic [31:0]          rdt_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdt_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (sel_i[l]) mem_q[adr_i][8*l +: 8] <= dat_i[8*l +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdt_q <= '0;
    end else if (clr_i) begin
      rdt_q <= '0;
    end else if (re_i) begin
      rdt_q <= mem_q[adr_i];
    end
  end

  assign rdt_o = rdt_q;

endmodule

// File: rtl/serv_dbus_rsp.sv
// -----------------------------------------------------------------------------
// serv_dbus_rsp
// Memory-side responder for the SERV data bus: a local data RAM that acks each
// request with a one-cycle pulse after WAIT wait states.
//
// Optional feature: define SERV_DBUS_RSP_ERR_EN to flag addresses with nonzero
// bits above the RAM as out of range (store dropped, load returns 0, o_wb_err
// set with ack). Without it the index wraps and o_wb_err is tied low.
//
// Ports:
//   i_clk, i_rst          clock, async active-high reset
//   i_wb_cyc              request valid, held until ack
//   i_wb_we               1 = store, 0 = load
//   i_wb_adr              byte address ([1:0] ignored)
//   i_wb_dat, i_wb_sel    store data and byte lane enables
//   o_wb_rdt              load data (registered, holds until next load)
//   o_wb_ack              single-cycle completion pulse
//   o_wb_err              out-of-range flag, coincident with ack
//   o_dbg_state           current FSM state (state_t encoding)
//
// Handshake: a request is accepted on any rising edge where the FSM is IDLE
// and i_wb_cyc=1; the master keeps i_wb_cyc and the request fields stable
// until it sees o_wb_ack. o_wb_ack is high for exactly one cycle, and the
// FSM ignores i_wb_cyc in that cycle, so a held request is re-accepted only
// in the following IDLE cycle.
// -----------------------------------------------------------------------------
module serv_dbus_rsp
  import serv_dbus_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WAIT  = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_wb_err,
  output logic [1:0]  o_dbg_state
);

  localparam int              AW      = $clog2(DEPTH);
  localparam bit              NO_WAIT = (WAIT == 0);
  localparam logic [CNT_W-1:0] WAIT_LD = (WAIT > 0) ? CNT_W'(WAIT - 1) : '0;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ack_q;
  logic                   err_q;

  // Captured request
  logic [AW-1:0]          idx_q;
  logic                   we_q;
  logic [NUM_LANES-1:0]   sel_q;
  logic [31:0]            dat_q;
  logic                   oor_q;

  logic                   bus_oor;
  logic                   unused_adr;

`ifdef SERV_DBUS_RSP_ERR_EN
  assign bus_oor    = |i_wb_adr[31:AW+2];
  assign unused_adr = ^i_wb_adr[1:0];
`else
  assign bus_oor    = 1'b0;
  assign unused_adr = ^{i_wb_adr[31:AW+2], i_wb_adr[1:0]};
`endif

  // Commit fires on the edge that enters ACK. With no wait states that is the
  // accepting edge itself, so the commit fields come straight from the bus;
  // otherwise they come from the captured request.
  logic                 from_bus;
  logic                 commit;
  logic                 c_we;
  logic                 c_oor;
  logic [AW-1:0]        c_idx;
  logic [NUM_LANES-1:0] c_sel;
  logic [31:0]          c_dat;

  always_comb begin
    from_bus = (state_q == ST_IDLE);
    commit   = 1'b0;
    if (!i_rst) begin
      if (from_bus) commit = i_wb_cyc && NO_WAIT;
      else          commit = (state_q == ST_WAIT) && (cnt_q == '0);
    end
    c_we  = from_bus ? i_wb_we               : we_q;
    c_oor = from_bus ? bus_oor               : oor_q;
    c_idx = from_bus ? i_wb_adr[AW+1:2]      : idx_q;
    c_sel = from_bus ? i_wb_sel              : sel_q;
    c_dat = from_bus ? i_wb_dat              : dat_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      oor_q   <= 1'b0;
    end else begin
      ack_q <= commit;
      err_q <= commit && c_oor;
      case (state_q)
        ST_IDLE: begin
          if (i_wb_cyc) begin
            idx_q <= i_wb_adr[AW+1:2];
            we_q  <= i_wb_we;
            sel_q <= i_wb_sel;
            dat_q <= i_wb_dat;
            oor_q <= bus_oor;
            if (NO_WAIT) begin
              state_q <= ST_ACK;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= WAIT_LD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_q == '0) state_q <= ST_ACK;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  serv_dbus_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .we_i  (commit && c_we && !c_oor),
    .sel_i (c_sel),
    .adr_i (c_idx),
    .dat_i (c_dat),
    .re_i  (commit && !c_we && !c_oor),
    .clr_i (commit && !c_we && c_oor),
    .rdt_o (o_wb_rdt)
  );

  assign o_wb_ack    = ack_q;
  assign o_wb_err    = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_serv_dbus_rsp.sv
// -----------------------------------------------------------------------------
// tb_serv_dbus_rsp
// Two responders (WAIT=0 on port 0, WAIT=3 on port 1, DEPTH=64) driven by
// task-level transactions. A reference model tracks memory contents, the
// expected ack cycle, read data and error flag per port; a compare process
// checks every port on every falling edge. Literal expectations pin the
// directed scenarios.
// -----------------------------------------------------------------------------
module tb_serv_dbus_rsp;
  import serv_dbus_pkg::*;

  logic        clk;
  logic        rst;
  logic        cyc   [2];
  logic        wbwe  [2];
  logic [31:0] adr   [2];
  logic [31:0] dat   [2];
  logic [3:0]  sel   [2];
  logic [31:0] rdt_o [2];
  logic        ack_o [2];
  logic        err_o [2];
  logic [1:0]  dbg_o [2];

  int total = 0;
  int bad   = 0;
  int cyc_cnt = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  // ---------------- DUTs ----------------
  serv_dbus_rsp #(.DEPTH(64), .WAIT(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc[0]), .i_wb_we(wbwe[0]),
    .i_wb_adr(adr[0]), .i_wb_dat(dat[0]), .i_wb_sel(sel[0]),
    .o_wb_rdt(rdt_o[0]), .o_wb_ack(ack_o[0]), .o_wb_err(err_o[0]),
    .o_dbg_state(dbg_o[0])
  );

  serv_dbus_rsp #(.DEPTH(64), .WAIT(3)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_wb_cyc(cyc[1]), .i_wb_we(wbwe[1]),
    .i_wb_adr(adr[1]), .i_wb_dat(dat[1]), .i_wb_sel(sel[1]),
    .o_wb_rdt(rdt_o[1]), .o_wb_ack(ack_o[1]), .o_wb_err(err_o[1]),
    .o_dbg_state(dbg_o[1])
  );

  // ---------------- reference model ----------------
  logic [31:0] mmem [2][64];
  logic [31:0] mrdt [2];
  logic        pending [2];
  int          ack_at [2];
  logic        r_we  [2];
  logic [5:0]  r_idx [2];
  logic [31:0] r_dat [2];
  logic [3:0]  r_sel [2];
  logic        r_oor [2];
  logic        e_ack;

  function automatic int wt(input int p);
    return (p == 0) ? 0 : 3;
  endfunction

  function automatic logic m_oor(input logic [31:0] a);
`ifdef SERV_DBUS_RSP_ERR_EN
    return (a[31:8] != 24'h0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      e_ack = pending[p] && (cyc_cnt == ack_at[p]);
      check($sformatf("ack p%0d", p), {31'h0, ack_o[p]}, {31'h0, e_ack});
      if (e_ack) begin
        pending[p] = 1'b0;
        if (r_we[p]) begin
          if (!r_oor[p]) begin
            for (int l = 0; l < 4; l++)
              if (r_sel[p][l]) mmem[p][r_idx[p]][8*l +: 8] = r_dat[p][8*l +: 8];
          end
        end else begin
          mrdt[p] = r_oor[p] ? 32'h0 : mmem[p][r_idx[p]];
        end
      end
      check($sformatf("rdt p%0d", p), rdt_o[p], mrdt[p]);
      check($sformatf("err p%0d", p), {31'h0, err_o[p]}, {31'h0, e_ack && r_oor[p]});
    end
  end

  // ---------------- driver tasks ----------------
  // Called on a falling edge while the port is idle; returns on the falling
  // edge of the idle cycle after the ack.
  task automatic xact(input int p, input logic we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input bit hold,
                      output logic [31:0] rdt, output logic err,
                      output int lat, output int ackc);
    int acc;
    bit got;
    cyc[p] = 1'b1; wbwe[p] = we; adr[p] = a; dat[p] = d; sel[p] = s;
    r_we[p] = we; r_idx[p] = a[7:2]; r_dat[p] = d; r_sel[p] = s; r_oor[p] = m_oor(a);
    acc = cyc_cnt + 1;
    ack_at[p] = acc + wt(p);
    pending[p] = 1'b1;
    got = 0; rdt = '0; err = 1'b0; lat = -1; ackc = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (ack_o[p]) begin
        got = 1; rdt = rdt_o[p]; err = err_o[p]; ackc = cyc_cnt; lat = cyc_cnt - acc + 1;
      end else begin
        // request fields are don't-care once accepted
        adr[p] = $urandom; dat[p] = $urandom; sel[p] = 4'($urandom); wbwe[p] = 1'($urandom);
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL timeout p%0d: no ack within 40 cycles", p);
      pending[p] = 1'b0;
    end
    if (!hold || !got) cyc[p] = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_check(input string tag);
    for (int p = 0; p < 2; p++) begin
      check($sformatf("%s ack p%0d", tag, p), {31'h0, ack_o[p]}, 32'h0);
      check($sformatf("%s err p%0d", tag, p), {31'h0, err_o[p]}, 32'h0);
      check($sformatf("%s rdt p%0d", tag, p), rdt_o[p], 32'h0);
      check($sformatf("%s state p%0d", tag, p), {30'h0, dbg_o[p]}, {30'h0, ST_IDLE});
    end
  endtask

  // Assert reset mid-cycle, check outputs immediately, release on next fall.
  task automatic mid_reset(input string tag);
    #2;
    rst = 1'b1;
    pending[0] = 1'b0; pending[1] = 1'b0;
    mrdt[0] = '0; mrdt[1] = '0;
    #1;
    reset_check(tag);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic        er;
  int          lat, ackc, ackc1;

  initial begin
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      cyc[p] = 1'b0; wbwe[p] = 1'b0; adr[p] = '0; dat[p] = '0; sel[p] = '0;
      pending[p] = 1'b0; ack_at[p] = -1; mrdt[p] = '0;
      r_we[p] = 1'b0; r_idx[p] = '0; r_dat[p] = '0; r_sel[p] = '0; r_oor[p] = 1'b0;
    end
    repeat (3) @(negedge clk);
    reset_check("por");
    rst = 1'b0;
    @(negedge clk);

    // Fill both memories so the model knows every word.
    for (int p = 0; p < 2; p++)
      for (int w = 0; w < 64; w++)
        xact(p, 1'b1, 32'(w * 4), $urandom, 4'hF, 0, rd, er, lat, ackc);

    // WAIT=0: full store then load.
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, ackc);
    check("w0 store lat", 32'(lat), 32'd1);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, ackc);
    check("w0 load lat", 32'(lat), 32'd1);
    check("w0 load rdt", rd, 32'hDEADBEEF);

    // Byte lanes.
    xact(0, 1'b1, 32'h10, 32'h00000055, 4'b0001, 0, rd, er, lat, ackc);
    xact(0, 1'b1, 32'h13, 32'h12000000, 4'b1000, 0, rd, er, lat, ackc);
    xact(0, 1'b0, 32'h11, 32'hFFFFFFFF, 4'b0000, 0, rd, er, lat, ackc);
    check("lanes rdt", rd, 32'h12ADBE55);

    // Store with no lanes leaves memory unchanged.
    xact(0, 1'b1, 32'h10, 32'hAAAAAAAA, 4'b0000, 0, rd, er, lat, ackc);
    xact(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat, ackc);
    check("sel0 rdt", rd, 32'h12ADBE55);

    mid_reset("midrst");

    // WAIT=3: held request, re-accepted only after the idle cycle.
    xact(1, 1'b1, 32'h10, 32'h5A5A0F0F, 4'hF, 0, rd, er, lat, ackc);
    xact(1, 1'b0, 32'h10, 32'h0, 4'hF, 1, rd, er, lat, ackc1);
    check("w3 lat", 32'(lat), 32'd4);
    check("w3 rdt", rd, 32'h5A5A0F0F);
    xact(1, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd, er, lat, ackc);
    check("w3 reaccept lat", 32'(lat), 32'd4);
    check("w3 ack spacing", 32'(ackc - ackc1), 32'd5);

    // Reset during a WAIT=3 store: store is dropped, no ack.
    xact(1, 1'b1, 32'h20, 32'h00000000, 4'hF, 0, rd, er, lat, ackc);
    cyc[1] = 1'b1; wbwe[1] = 1'b1; adr[1] = 32'h20; dat[1] = 32'hFFFFFFFF; sel[1] = 4'hF;
    @(negedge clk);
    cyc[1] = 1'b0;
    mid_reset("waitrst");
    xact(1, 1'b0, 32'h20, 32'h0, 4'hF, 0, rd, er, lat, ackc);
    check("dropped store rdt", rd, 32'h00000000);

    // Out-of-range address.
    xact(0, 1'b1, 32'h0, 32'h11111111, 4'hF, 0, rd, er, lat, ackc);
    xact(0, 1'b1, 32'h100, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, ackc);
`ifdef SERV_DBUS_RSP_ERR_EN
    check("oor store err", {31'h0, er}, 32'h1);
`else
    check("oor store err", {31'h0, er}, 32'h0);
`endif
    xact(0, 1'b0, 32'h100, 32'h0, 4'hF, 0, rd, er, lat, ackc);
`ifdef SERV_DBUS_RSP_ERR_EN
    check("oor load err", {31'h0, er}, 32'h1);
    check("oor load rdt", rd, 32'h00000000);
`else
    check("oor load err", {31'h0, er}, 32'h0);
    check("oor load rdt", rd, 32'hCAFEF00D);
`endif
    xact(0, 1'b0, 32'h0, 32'h0, 4'hF, 0, rd, er, lat, ackc);
`ifdef SERV_DBUS_RSP_ERR_EN
    check("word0 rdt", rd, 32'h11111111);
`else
    check("word0 rdt", rd, 32'hCAFEF00D);
`endif
    check("word0 err", {31'h0, er}, 32'h0);

    // Randomized traffic, checked by the compare process.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 120; i++) begin
        logic [31:0] a;
        bit h;
        a = $urandom;
        if ($urandom_range(0, 3) != 0) a[31:8] = 24'h0;
        h = (i < 119) && ($urandom_range(0, 3) == 0);
        xact(p, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), h, rd, er, lat, ackc);
        check($sformatf("rand lat p%0d", p), 32'(lat), 32'(wt(p) + 1));
      end
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serv_dbus_rsp.md
# serv_dbus_rsp

Data-bus responder for the SERV core: the memory-side end of the data bus on which the core's load/store buffer drives address, write data and byte selects and latches read data on acknowledge. It holds a word-addressed register-file memory with per-byte write enables, returns a full 32-bit read word, and signals completion with a single-cycle acknowledge after a configurable number of wait states. It sits between the core's dbus port and the rest of the SoC as a local data RAM.

## Interface
- DEPTH, 64: number of 32-bit words; power of two, ≥2. AW = $clog2(DEPTH), derived, not overridable.
- WAIT, 0: wait states inserted between request acceptance and acknowledge; 0..15.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_wb_cyc  in  1  request valid; held high until ack is seen.
- i_wb_we  in  1  1 = store, 0 = load.
- i_wb_adr  in  32  byte address; bits [1:0] ignored.
- i_wb_dat  in  32  store data.
- i_wb_sel  in  4  byte lane enables; bit n covers dat[8n+7:8n].
- o_wb_rdt  out  32  load data; valid when o_wb_ack is high.
- o_wb_ack  out  1  single-cycle completion pulse.
- o_wb_err  out  1  out-of-range flag, coincident with ack (see Configuration).

## Operation
- FSM states: IDLE, WAIT, ACK. Reset: IDLE, o_wb_ack=0, o_wb_err=0, o_wb_rdt=0, wait counter 0. Memory array is not reset.
- IDLE: i_wb_cyc=1 at an edge accepts the request; index = i_wb_adr[AW+1:2], we, sel, dat and range flag captured into request registers. Next: WAIT if WAIT>0 (counter loaded with WAIT-1), else ACK.
- WAIT: counter decrements each edge; at 0 -> ACK. Bus inputs ignored.
- Commit happens at the edge entering ACK: store writes only lanes with sel=1, others keep old value; load captures full word into o_wb_rdt regardless of sel. Store leaves o_wb_rdt unchanged.
- ACK: o_wb_ack=1 for exactly one cycle; next state always IDLE. i_wb_cyc during ACK is ignored (no re-acceptance in the ACK cycle).
- Back-to-back: cyc high in the first IDLE cycle after ACK starts a new transaction; max throughput one transaction per WAIT+2 cycles.
- Store with sel=0000: completes and acks, memory unchanged.
- Reset asserted mid-transaction: FSM returns to IDLE immediately, pending store is dropped, ack never issued.

## Timing
- Request high in IDLE in cycle 0 -> o_wb_ack high in cycle 1+WAIT, low in cycle 2+WAIT.
- o_wb_rdt and o_wb_err registered; valid in the ack cycle; o_wb_rdt holds until the next load commits.
- Store visible to a load accepted in any cycle after the ack cycle.
- No combinational path from any input to any output.

## Configuration
- SERV_DBUS_RSP_ERR_EN defined: address with i_wb_adr[31:AW+2] ≠ 0 is out of range; store is dropped, load returns 0x00000000, o_wb_err=1 in the ack cycle. Ack timing unchanged.
- Undefined: upper address bits ignored, index wraps modulo DEPTH; o_wb_err tied 0; no range comparator built.

## Structure
- Shared package serv_dbus_pkg: FSM state encoding (IDLE/WAIT/ACK), WAIT counter width constant (4), byte-lane count constant (4).
- One sub-module: serv_dbus_ram — DEPTH×32 array, synchronous read, per-byte write enable; top holds FSM, request registers, counter and error logic.

## Test plan
- Reset: assert i_rst mid-cycle -> ack=0, err=0, rdt=0x00000000 immediately, FSM IDLE.
- WAIT=0: store 0xDEADBEEF sel=1111 to 0x10, then load 0x10 -> each ack exactly 1 cycle after accept; rdt=0xDEADBEEF.
- Byte lanes: over 0xDEADBEEF at 0x10 store 0x00000055 sel=0001, then 0x12000000 sel=1000 -> load returns 0x12ADBE55.
- WAIT=3: load accepted cycle 0 -> ack only in cycle 4; cyc held high through ACK causes no second ack until re-accept in cycle 5 (ack cycle 9).
- Reset during WAIT=3 store of 0xFFFFFFFF to 0x20 (old 0x0) -> no ack; subsequent load returns 0x00000000.
- ERR_EN, DEPTH=64: store to 0x100 then load 0x100 -> err=1 with both acks, rdt=0; load 0x0 unchanged. Without macro: same store aliases to word 0, load 0x0 returns stored value, err=0.
